// File: rtl/dm_arbiter_if.sv
// Requester, memory and status signals of dm_arbiter, bundled as one interface.
// The slave side is the arbiter; the master side drives requests and models the memory.
interface dm_arbiter_if #(
    parameter int unsigned ADDR_W = 10
);
    logic              p0_req;
    logic              p1_req;
    logic              p0_we;
    logic              p1_we;
    logic [ADDR_W-1:0] p0_addr;
    logic [ADDR_W-1:0] p1_addr;
    logic [31:0]       p0_wdata;
    logic [31:0]       p1_wdata;
    logic              p0_ack;
    logic              p1_ack;
    logic              p0_err;
    logic              p1_err;
    logic [31:0]       rdata;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              busy;
    logic              owner;
    logic [1:0]        watch_stat;

    modport slave (
        input  p0_req, p1_req, p0_we, p1_we, p0_addr, p1_addr, p0_wdata, p1_wdata, mem_rdata,
        output p0_ack, p1_ack, p0_err, p1_err, rdata, mem_en, mem_we, mem_addr, mem_wdata,
        output busy, owner, watch_stat
    );

    modport master (
        output p0_req, p1_req, p0_we, p1_we, p0_addr, p1_addr, p0_wdata, p1_wdata, mem_rdata,
        input  p0_ack, p1_ack, p0_err, p1_err, rdata, mem_en, mem_we, mem_addr, mem_wdata,
        input  busy, owner, watch_stat
    );
endinterface

// File: rtl/dm_arbiter.sv
// Two-port arbiter in front of a single-port synchronous data memory.
// One word access at a time through IDLE -> ACC -> RESP, ending in a one-cycle ack.
module dm_arbiter #(
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned DEPTH      = 1024,
    parameter bit          FIXED_PRIO = 1'b0
) (
    input logic         clk,
    input logic         rst,
    dm_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StAcc  = 2'b01,
        StResp = 2'b10
    } state_e;

    state_e            state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_owner_q, last_owner_d;
    logic              oor_q, oor_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;

    logic              grant;
    logic              win;
    logic [ADDR_W-1:0] win_addr;

    // Winner selection; only consumed by the IDLE next-state logic.
    always_comb begin
        grant = bus.p0_req | bus.p1_req;
        if (bus.p0_req && bus.p1_req) begin
            win = FIXED_PRIO ? 1'b0 : ~last_owner_q;
        end else begin
            win = bus.p1_req;
        end
        win_addr = win ? bus.p1_addr : bus.p0_addr;
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        oor_d        = oor_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        case (state_q)
            StIdle: begin
                if (grant) begin
                    state_d      = StAcc;
                    owner_d      = win;
                    last_owner_d = win;
                    we_d         = win ? bus.p1_we : bus.p0_we;
                    addr_d       = win_addr;
                    wdata_d      = win ? bus.p1_wdata : bus.p0_wdata;
                    oor_d        = (32'(win_addr) >= DEPTH);
                end
            end
            StAcc:   state_d = StResp;
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            oor_q        <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            oor_q        <= oor_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
        end
    end

    // Outputs depend on state and latched registers only, so reset clears them at once.
    always_comb begin
        bus.mem_en     = 1'b0;
        bus.mem_we     = 1'b0;
        bus.mem_addr   = '0;
        bus.mem_wdata  = '0;
        bus.p0_ack     = 1'b0;
        bus.p1_ack     = 1'b0;
        bus.p0_err     = 1'b0;
        bus.p1_err     = 1'b0;
        bus.rdata      = '0;
        bus.busy       = (state_q != StIdle);
        bus.owner      = owner_q;
        bus.watch_stat = state_q;
        case (state_q)
            StAcc: begin
                bus.mem_en    = ~oor_q;
                bus.mem_we    = we_q & ~oor_q;
                bus.mem_addr  = addr_q;
                bus.mem_wdata = wdata_q;
            end
            StResp: begin
                bus.p0_ack = ~owner_q;
                bus.p1_ack = owner_q;
                bus.p0_err = ~owner_q & oor_q;
                bus.p1_err = owner_q & oor_q;
                bus.rdata  = (oor_q || we_q) ? 32'h0 : bus.mem_rdata;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: two instances (round-robin/1024 words, fixed-priority/512 words),
// a transaction-level model with a shadow memory, and directed scenarios with literal checks.
`timescale 1ns/1ps
module tb_dm_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dm_arbiter_if #(.ADDR_W(10)) bus0 ();
    dm_arbiter_if #(.ADDR_W(10)) bus1 ();

    dm_arbiter #(.ADDR_W(10), .DEPTH(1024), .FIXED_PRIO(1'b0)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0)
    );
    dm_arbiter #(.ADDR_W(10), .DEPTH(512), .FIXED_PRIO(1'b1)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1)
    );

    // Memories serving the DUTs: read data appears the cycle after mem_en.
    logic [31:0] mem0 [1024];
    logic [31:0] mem1 [1024];
    always @(posedge clk) begin
        if (bus0.mem_en) begin
            bus0.mem_rdata <= mem0[bus0.mem_addr];
            if (bus0.mem_we) mem0[bus0.mem_addr] = bus0.mem_wdata;
        end
        if (bus1.mem_en) begin
            bus1.mem_rdata <= mem1[bus1.mem_addr];
            if (bus1.mem_we) mem1[bus1.mem_addr] = bus1.mem_wdata;
        end
    end

    // Transaction-level model: a phase counter since grant plus the accepted request.
    int unsigned m_ph   [2];
    logic        m_own  [2];
    logic        m_last [2];
    logic        m_we   [2];
    logic        m_oor  [2];
    logic [9:0]  m_addr [2];
    logic [31:0] m_wd   [2];
    logic [31:0] sh     [2][1024];

    typedef struct {
        int          port;
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } ack_t;
    ack_t q0[$];
    ack_t q1[$];
    int   en_cnt [2];
    int   we_cnt [2];

    function automatic logic [31:0] pat(input int i);
        return 32'hA500_0000 | 32'(i);
    endfunction

    function automatic int depth_of(input int k);
        return (k == 0) ? 1024 : 512;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic model_reset(input int k);
        m_ph[k]   = 0;
        m_own[k]  = 1'b0;
        m_last[k] = 1'b1;
        m_we[k]   = 1'b0;
        m_oor[k]  = 1'b0;
        m_addr[k] = '0;
        m_wd[k]   = '0;
    endtask

    task automatic model_step(input int k, input logic r0, input logic w0, input logic [9:0] a0,
                              input logic [31:0] d0, input logic r1, input logic w1,
                              input logic [9:0] a1, input logic [31:0] d1);
        logic win;
        if (m_ph[k] == 0) begin
            if (r0 || r1) begin
                if (r0 && r1) win = (k == 1) ? 1'b0 : !m_last[k];
                else win = r1;
                m_own[k]  = win;
                m_last[k] = win;
                m_we[k]   = win ? w1 : w0;
                m_addr[k] = win ? a1 : a0;
                m_wd[k]   = win ? d1 : d0;
                m_oor[k]  = (int'(m_addr[k]) >= depth_of(k));
                m_ph[k]   = 1;
            end
        end else if (m_ph[k] == 1) begin
            if (m_we[k] && !m_oor[k]) sh[k][m_addr[k]] = m_wd[k];
            m_ph[k] = 2;
        end else begin
            m_ph[k] = 0;
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            model_reset(0);
            model_reset(1);
        end else begin
            model_step(0, bus0.p0_req, bus0.p0_we, bus0.p0_addr, bus0.p0_wdata,
                       bus0.p1_req, bus0.p1_we, bus0.p1_addr, bus0.p1_wdata);
            model_step(1, bus1.p0_req, bus1.p0_we, bus1.p0_addr, bus1.p0_wdata,
                       bus1.p1_req, bus1.p1_we, bus1.p1_addr, bus1.p1_wdata);
        end
    end

    task automatic check_inst(input int k, input logic busy, input logic own,
                              input logic [1:0] ws, input logic a0, input logic a1,
                              input logic e0, input logic e1, input logic [31:0] rd,
                              input logic en, input logic mwe, input logic [9:0] maddr,
                              input logic [31:0] mwd);
        string t;
        logic  acc;
        logic  rsp;
        ack_t  rec;
        acc = (m_ph[k] == 1);
        rsp = (m_ph[k] == 2);
        t = $sformatf("inst%0d cyc%0d", k, cyc);
        chk({t, " busy"}, 32'(busy), 32'(m_ph[k] != 0));
        chk({t, " watch_stat"}, 32'(ws), m_ph[k]);
        chk({t, " owner"}, 32'(own), 32'(m_own[k]));
        chk({t, " mem_en"}, 32'(en), 32'(acc && !m_oor[k]));
        chk({t, " mem_we"}, 32'(mwe), 32'(acc && !m_oor[k] && m_we[k]));
        if (acc) begin
            chk({t, " mem_addr"}, 32'(maddr), 32'(m_addr[k]));
            chk({t, " mem_wdata"}, mwd, m_wd[k]);
        end
        chk({t, " p0_ack"}, 32'(a0), 32'(rsp && !m_own[k]));
        chk({t, " p1_ack"}, 32'(a1), 32'(rsp && m_own[k]));
        chk({t, " p0_err"}, 32'(e0), 32'(rsp && !m_own[k] && m_oor[k]));
        chk({t, " p1_err"}, 32'(e1), 32'(rsp && m_own[k] && m_oor[k]));
        chk({t, " rdata"}, rd, (rsp && !m_oor[k] && !m_we[k]) ? sh[k][m_addr[k]] : 32'h0);
        if (a0 || a1) begin
            rec.port  = a1 ? 1 : 0;
            rec.rdata = rd;
            rec.err   = a1 ? e1 : e0;
            rec.cyc   = cyc + 1;
            if (k == 0) q0.push_back(rec);
            else q1.push_back(rec);
        end
        if (en) en_cnt[k]++;
        if (mwe) we_cnt[k]++;
    endtask

    always @(negedge clk) begin
        check_inst(0, bus0.busy, bus0.owner, bus0.watch_stat, bus0.p0_ack, bus0.p1_ack,
                   bus0.p0_err, bus0.p1_err, bus0.rdata, bus0.mem_en, bus0.mem_we,
                   bus0.mem_addr, bus0.mem_wdata);
        check_inst(1, bus1.busy, bus1.owner, bus1.watch_stat, bus1.p0_ack, bus1.p1_ack,
                   bus1.p0_err, bus1.p1_err, bus1.rdata, bus1.mem_en, bus1.mem_we,
                   bus1.mem_addr, bus1.mem_wdata);
    end

    function automatic int qsize(input int k);
        return (k == 0) ? q0.size() : q1.size();
    endfunction

    function automatic ack_t qat(input int k, input int i);
        return (k == 0) ? q0[i] : q1[i];
    endfunction

    task automatic wait_acks(input int k, input int n, input int budget);
        int i = 0;
        while (qsize(k) < n && i < budget) begin
            @(posedge clk);
            i++;
        end
        chk($sformatf("inst%0d ack count within %0d cycles", k, budget), qsize(k), n);
    endtask

    task automatic set_req(input int k, input int p, input logic req, input logic we,
                           input logic [9:0] addr, input logic [31:0] wd);
        if (k == 0 && p == 0) begin
            bus0.p0_req = req; bus0.p0_we = we; bus0.p0_addr = addr; bus0.p0_wdata = wd;
        end else if (k == 0) begin
            bus0.p1_req = req; bus0.p1_we = we; bus0.p1_addr = addr; bus0.p1_wdata = wd;
        end else if (p == 0) begin
            bus1.p0_req = req; bus1.p0_we = we; bus1.p0_addr = addr; bus1.p0_wdata = wd;
        end else begin
            bus1.p1_req = req; bus1.p1_we = we; bus1.p1_addr = addr; bus1.p1_wdata = wd;
        end
    endtask

    task automatic idle_all();
        for (int k = 0; k < 2; k++) begin
            set_req(k, 0, 1'b0, 1'b0, 10'd0, 32'h0);
            set_req(k, 1, 1'b0, 1'b0, 10'd0, 32'h0);
        end
    endtask

    task automatic preload(input int k, input int a, input logic [31:0] v);
        sh[k][a] = v;
        if (k == 0) mem0[a] = v;
        else mem1[a] = v;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, required finish before timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int   base;
        int   start;
        int   en0;
        int   we0;
        ack_t a;

        model_reset(0);
        model_reset(1);
        en_cnt = '{0, 0};
        we_cnt = '{0, 0};
        for (int i = 0; i < 1024; i++) begin
            preload(0, i, pat(i));
            preload(1, i, pat(i));
        end
        preload(0, 5, 32'hDEAD_BEEF);
        for (int k = 0; k < 2; k++) begin
            preload(k, 10, 32'hA0A0_0010);
            preload(k, 20, 32'hB0B0_0020);
        end
        idle_all();

        // Reset state
        @(posedge clk); #1;
        chk("reset busy", 32'(bus0.busy), 0);
        chk("reset watch_stat", 32'(bus0.watch_stat), 0);
        chk("reset owner", 32'(bus0.owner), 0);
        chk("reset mem_en", 32'(bus0.mem_en), 0);
        chk("reset rdata", bus0.rdata, 32'h0);
        @(negedge clk) rst = 1'b0;

        // Contention, round-robin: both held from right after reset
        @(posedge clk); #1;
        start = cyc;
        set_req(0, 0, 1'b1, 1'b0, 10'd10, 32'h0);
        set_req(0, 1, 1'b1, 1'b0, 10'd20, 32'h0);
        wait_acks(0, 4, 40);
        #1 idle_all();
        if (q0.size() >= 4) begin
            chk("rr first ack latency", q0[0].cyc - start, 3);
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("rr grant %0d port", i), q0[i].port, i % 2);
                chk($sformatf("rr grant %0d rdata", i), q0[i].rdata,
                    (i % 2 == 0) ? 32'hA0A0_0010 : 32'hB0B0_0020);
                if (i > 0) chk($sformatf("rr ack spacing %0d", i), q0[i].cyc - q0[i-1].cyc, 3);
            end
        end

        // Contention, fixed priority: port 0 wins while it holds req
        @(posedge clk); #1;
        set_req(1, 0, 1'b1, 1'b0, 10'd10, 32'h0);
        set_req(1, 1, 1'b1, 1'b0, 10'd20, 32'h0);
        wait_acks(1, 3, 40);
        #1 set_req(1, 0, 1'b0, 1'b0, 10'd0, 32'h0);
        wait_acks(1, 4, 20);
        #1 idle_all();
        for (int i = 0; i < q1.size() && i < 4; i++) begin
            chk($sformatf("fp ack %0d port", i), q1[i].port, (i < 3) ? 0 : 1);
        end

        // Single read
        @(posedge clk); #1;
        base = q0.size(); en0 = en_cnt[0]; start = cyc;
        set_req(0, 0, 1'b1, 1'b0, 10'd5, 32'h0);
        wait_acks(0, base + 1, 10);
        #1 idle_all();
        if (q0.size() > base) begin
            a = qat(0, base);
            chk("read port", a.port, 0);
            chk("read rdata", a.rdata, 32'hDEAD_BEEF);
            chk("read err", 32'(a.err), 0);
            chk("read latency", a.cyc - start, 3);
        end
        chk("read mem_en cycles", en_cnt[0] - en0, 1);

        // Write then read on port 1 at the top address
        @(posedge clk); #1;
        base = q0.size(); we0 = we_cnt[0];
        set_req(0, 1, 1'b1, 1'b1, 10'h3FF, 32'h1234_5678);
        wait_acks(0, base + 1, 10);
        #1 set_req(0, 1, 1'b1, 1'b0, 10'h3FF, 32'h0);
        wait_acks(0, base + 2, 10);
        #1 idle_all();
        chk("write mem_we cycles", we_cnt[0] - we0, 1);
        chk("write committed", mem0[1023], 32'h1234_5678);
        if (q0.size() > base + 1) begin
            chk("write ack rdata", qat(0, base).rdata, 32'h0);
            chk("readback port", qat(0, base + 1).port, 1);
            chk("readback rdata", qat(0, base + 1).rdata, 32'h1234_5678);
        end

        // Out of range write on the 512-word instance
        @(posedge clk); #1;
        base = q1.size(); en0 = en_cnt[1];
        set_req(1, 0, 1'b1, 1'b1, 10'd600, 32'hCAFE_F00D);
        wait_acks(1, base + 1, 10);
        #1 idle_all();
        chk("oor mem_en cycles", en_cnt[1] - en0, 0);
        chk("oor memory unchanged", mem1[600], 32'hA500_0258);
        if (q1.size() > base) begin
            chk("oor port", qat(1, base).port, 0);
            chk("oor err", 32'(qat(1, base).err), 1);
            chk("oor rdata", qat(1, base).rdata, 32'h0);
        end

        // Inputs change during ACC
        @(posedge clk); #1;
        base = q0.size();
        set_req(0, 0, 1'b1, 1'b0, 10'd7, 32'h0);
        @(posedge clk); #1;
        set_req(0, 0, 1'b0, 1'b0, 10'd9, 32'h0);
        #1;
        chk("mid-acc mem_addr", 32'(bus0.mem_addr), 7);
        chk("mid-acc mem_en", 32'(bus0.mem_en), 1);
        wait_acks(0, base + 1, 10);
        if (q0.size() > base) begin
            chk("mid-acc ack port", qat(0, base).port, 0);
            chk("mid-acc rdata", qat(0, base).rdata, 32'hA500_0007);
        end

        // Reset during ACC of a write
        @(posedge clk); #1;
        base = q0.size();
        set_req(0, 1, 1'b1, 1'b1, 10'd30, 32'h55AA_55AA);
        @(posedge clk); #1;
        chk("pre-reset mem_we", 32'(bus0.mem_we), 1);
        #2 rst = 1'b1;
        #1;
        chk("async reset mem_en", 32'(bus0.mem_en), 0);
        chk("async reset mem_we", 32'(bus0.mem_we), 0);
        chk("async reset watch_stat", 32'(bus0.watch_stat), 0);
        chk("async reset p1_ack", 32'(bus0.p1_ack), 0);
        idle_all();
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        repeat (3) @(posedge clk);
        chk("aborted write no ack", q0.size(), base);
        chk("aborted write not committed", mem0[30], 32'hA500_001E);
        #1;
        set_req(0, 0, 1'b1, 1'b0, 10'd10, 32'h0);
        set_req(0, 1, 1'b1, 1'b0, 10'd20, 32'h0);
        wait_acks(0, base + 1, 10);
        #1 idle_all();
        if (q0.size() > base) chk("post-reset tie winner", qat(0, base).port, 0);

        repeat (4) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
